wb_unit: RTL

- Writeback stage; the consuming end of the issue/writeback handshake.
- Accepts one issued instruction record per cycle (valid, type, rd, pc, imm) and forms the destination result.
- For load-class (MEM) instructions, stalls the issuer until the memory unit returns data.
- Drives the register-file write port and a retire counter, and returns wb_rdy to the issue side.

---
 rtl/wb_unit_pkg.sv | 27 ++
 rtl/wb_result_sel.sv | 41 ++++
 rtl/wb_unit.sv | 82 ++++++++
 3 files changed

// File: rtl/wb_unit_pkg.sv
// Shared types for the writeback stage: instruction class codes and FSM state encodings.
// Class codes must match the issue side's encoding (ALU=0 .. NONE=5; 6-7 behave as NONE).
package wb_unit_pkg;

   typedef enum logic [2:0] {
      TYPE_ALU   = 3'd0,
      TYPE_MEM   = 3'd1,
      TYPE_LUI   = 3'd2,
      TYPE_AUIPC = 3'd3,
      TYPE_JAL   = 3'd4,
      TYPE_NONE  = 3'd5
   } wb_type_t;

   typedef enum logic {
      ST_IDLE     = 1'b0,
      ST_MEM_WAIT = 1'b1
   } wb_state_t;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned REG_AW   = 5;
   localparam logic [XLEN-1:0] LINK_OFFSET = 32'd4;

   function automatic logic is_mem(input logic [2:0] t);
      return t == TYPE_MEM;
   endfunction

endpackage

// File: rtl/wb_result_sel.sv
// Combinational result mux for non-load records; zero latency, no flow control.
// 'writes' is low for classes that never update the register file (stores, branches, unused codes).
module wb_result_sel
   import wb_unit_pkg::*;
(
   input  logic [2:0]      type_in,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] imm,
   input  logic [XLEN-1:0] alu_result,
   output logic [XLEN-1:0] result,
   output logic            writes
);

   always_comb begin
      result = '0;
      writes = 1'b0;
      case (type_in)
         TYPE_ALU: begin
            result = alu_result;
            writes = 1'b1;
         end
         TYPE_LUI: begin
            result = imm;
            writes = 1'b1;
         end
         TYPE_AUIPC: begin
            result = pc + imm;
            writes = 1'b1;
         end
         TYPE_JAL: begin
            result = pc + LINK_OFFSET;
            writes = 1'b1;
         end
         default: begin
            result = '0;
            writes = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/wb_unit.sv
// Writeback stage: one record per cycle, register-file write one cycle after accept (loads: one cycle after mem_done).
// wb_rdy drops combinationally when a load is presented and stays low until its data is written back.
module wb_unit
   import wb_unit_pkg::*;
#(
   parameter int unsigned RETIRE_W = 32
)
(
   input  logic                clk,
   input  logic                rst,
   input  logic                rdy,
   input  logic                rd_rdy,
   input  logic [2:0]          type_in,
   input  logic [REG_AW-1:0]   rd_in,
   input  logic [XLEN-1:0]     pc_in,
   input  logic [XLEN-1:0]     imm_in,
   input  logic [XLEN-1:0]     alu_result,
   input  logic                mem_done,
   input  logic [XLEN-1:0]     mem_data,
   output logic                wb_rdy,
   output logic                reg_we,
   output logic [REG_AW-1:0]   reg_rd,
   output logic [XLEN-1:0]     reg_data,
   output logic [RETIRE_W-1:0] retire_cnt
);

   wb_state_t         state;
   logic [REG_AW-1:0] pend_rd;
   logic [XLEN-1:0]   sel_result;
   logic              sel_writes;

   wb_result_sel u_sel (
      .type_in    (type_in),
      .pc         (pc_in),
      .imm        (imm_in),
      .alu_result (alu_result),
      .result     (sel_result),
      .writes     (sel_writes)
   );

   // Dropping in the same cycle a load is presented keeps the issuer from re-arming on a stale high.
   assign wb_rdy = !rst && (state == ST_IDLE) && !(rd_rdy && is_mem(type_in));

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         pend_rd    <= '0;
         reg_we     <= 1'b0;
         reg_rd     <= '0;
         reg_data   <= '0;
         retire_cnt <= '0;
      end else if (rdy) begin
         reg_we <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (rd_rdy) begin
                  if (is_mem(type_in)) begin
                     pend_rd <= rd_in;
                     state   <= ST_MEM_WAIT;
                  end else begin
                     reg_we     <= sel_writes && (rd_in != '0);
                     reg_rd     <= rd_in;
                     reg_data   <= sel_result;
                     retire_cnt <= retire_cnt + 1'b1;
                  end
               end
            end
            ST_MEM_WAIT: begin
               if (mem_done) begin
                  reg_we     <= (pend_rd != '0);
                  reg_rd     <= pend_rd;
                  reg_data   <= mem_data;
                  retire_cnt <= retire_cnt + 1'b1;
                  state      <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
